pipe_ctrl: RTL and testbench

Generates and scrolls the two pipe obstacles for the game and drives the nearest-pipe coordinates (pip1_X/pip1_Y) that the bird controller uses for collision. Runs on the 1 ms game tick. Gap heights come from a free-running LFSR. Counts passed pipes (score) and emits a one-cycle pass pulse for the display and sound blocks.

---
 rtl/pipe_ctrl.sv | 138 +++++++++++++
 tb/tb_pipe_ctrl.sv | 188 ++++++++++++++++++
 2 files changed

// File: rtl/pipe_ctrl.sv
// Pipe obstacle generator: scrolls two pipes on the 1 ms game tick, respawns them
// with LFSR-driven gap heights, and tracks the nearest unpassed pipe and the score.
module pipe_ctrl #(
  parameter int SCROLL_DIV = 8,
  parameter int SPACING    = 320,
  parameter int RESPAWN_X  = 639,
  parameter int BIRD_X     = 320,
  parameter int Y_MIN      = 220,
  parameter int SCORE_MAX  = 1023
) (
  input  logic       clk_ms,
  input  logic       rst_n,
  input  logic [1:0] state,
  output logic [9:0] pip1_X,
  output logic [8:0] pip1_Y,
  output logic [9:0] pip2_X,
  output logic [8:0] pip2_Y,
  output logic [9:0] score,
  output logic       pass_pulse
);

  localparam logic [9:0]  XA_START = 10'(2 * SPACING);
  localparam logic [9:0]  XB_START = 10'(3 * SPACING);
  localparam logic [8:0]  Y_START  = 9'd348;
  localparam logic [15:0] LFSR_SEED = 16'hACE1;
  localparam logic [1:0]  ST_IDLE  = 2'd0;
  localparam logic [1:0]  ST_PLAY  = 2'd1;

  logic [9:0]  r_xa, r_xb;
  logic [8:0]  r_ya, r_yb;
  logic        r_sel;
  logic [2:0]  r_div;
  logic [15:0] r_lfsr;
  logic [9:0]  r_score;
  logic        r_pass;

  logic [9:0]  w_xa, w_xb;
  logic [8:0]  w_ya, w_yb;
  logic        w_sel;
  logic [2:0]  w_div;
  logic [15:0] w_lfsr;
  logic [9:0]  w_score;
  logic        w_pass_nxt;

  logic        w_lfsr_fb;
  logic [8:0]  w_rand_a, w_rand_b;
  logic        w_tick;
  logic [9:0]  w_pip1_x;
  logic        w_pass;

  // Fibonacci LFSR, taps 16,14,13,11, shifting toward bit 0
  assign w_lfsr_fb = r_lfsr[0] ^ r_lfsr[2] ^ r_lfsr[3] ^ r_lfsr[5];
  assign w_lfsr    = {w_lfsr_fb, r_lfsr[15:1]};

  assign w_rand_a = 9'(Y_MIN) + {1'b0, r_lfsr[7:0]};
  assign w_rand_b = 9'(Y_MIN) + {1'b0, r_lfsr[15:8]};
  assign w_tick   = (r_div == 3'(SCROLL_DIV - 1));
  assign w_pip1_x = r_sel ? r_xb : r_xa;
  assign w_pass   = w_tick && (w_pip1_x == 10'(BIRD_X));

  always_comb begin
    w_xa       = r_xa;
    w_xb       = r_xb;
    w_ya       = r_ya;
    w_yb       = r_yb;
    w_sel      = r_sel;
    w_div      = r_div;
    w_score    = r_score;
    w_pass_nxt = 1'b0;
    case (state)
      ST_IDLE: begin
        w_xa    = XA_START;
        w_xb    = XB_START;
        w_ya    = w_rand_a;
        w_yb    = w_rand_b;
        w_sel   = 1'b0;
        w_div   = 3'd0;
        w_score = 10'd0;
      end
      ST_PLAY: begin
        w_div = w_tick ? 3'd0 : r_div + 3'd1;
        if (w_tick) begin
          // Zero check precedes the decrement so X never wraps
          if (r_xa == 10'd0) begin
            w_xa = 10'(RESPAWN_X);
            w_ya = w_rand_a;
          end else begin
            w_xa = r_xa - 10'd1;
          end
          if (r_xb == 10'd0) begin
            w_xb = 10'(RESPAWN_X);
            w_yb = w_rand_b;
          end else begin
            w_xb = r_xb - 10'd1;
          end
        end
        if (w_pass) begin
          w_score    = (r_score >= 10'(SCORE_MAX)) ? 10'(SCORE_MAX) : r_score + 10'd1;
          w_sel      = ~r_sel;
          w_pass_nxt = 1'b1;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk_ms or negedge rst_n) begin
    if (!rst_n) begin
      r_xa    <= XA_START;
      r_xb    <= XB_START;
      r_ya    <= Y_START;
      r_yb    <= Y_START;
      r_sel   <= 1'b0;
      r_div   <= 3'd0;
      r_lfsr  <= LFSR_SEED;
      r_score <= 10'd0;
      r_pass  <= 1'b0;
    end else begin
      r_xa    <= w_xa;
      r_xb    <= w_xb;
      r_ya    <= w_ya;
      r_yb    <= w_yb;
      r_sel   <= w_sel;
      r_div   <= w_div;
      r_lfsr  <= w_lfsr;
      r_score <= w_score;
      r_pass  <= w_pass_nxt;
    end
  end

  assign pip1_X     = r_sel ? r_xb : r_xa;
  assign pip1_Y     = r_sel ? r_yb : r_ya;
  assign pip2_X     = r_sel ? r_xa : r_xb;
  assign pip2_Y     = r_sel ? r_ya : r_yb;
  assign score      = r_score;
  assign pass_pulse = r_pass;

endmodule

// File: tb/tb_pipe_ctrl.sv
// Directed bench for pipe_ctrl: scroll timing, passes, respawn, freeze/idle,
// score saturation (small SCORE_MAX instance) and asynchronous reset.
module tb_pipe_ctrl;

  logic       clk_ms = 1'b0;
  logic       rst_n  = 1'b1;
  logic [1:0] st_main = 2'd0;
  logic [1:0] st_sat  = 2'd0;

  logic [9:0] m_p1x, m_p2x, m_score;
  logic [8:0] m_p1y, m_p2y;
  logic       m_pass;
  logic [9:0] s_p1x, s_p2x, s_score;
  logic [8:0] s_p1y, s_p2y;
  logic       s_pass;

  int checks   = 0;
  int failures = 0;

  logic [15:0] m_lfsr, m_prev;
  logic [31:0] exp_ya, exp_yb, y_new;

  pipe_ctrl dut (
    .clk_ms(clk_ms), .rst_n(rst_n), .state(st_main),
    .pip1_X(m_p1x), .pip1_Y(m_p1y), .pip2_X(m_p2x), .pip2_Y(m_p2y),
    .score(m_score), .pass_pulse(m_pass)
  );

  pipe_ctrl #(.SCORE_MAX(3)) u_sat (
    .clk_ms(clk_ms), .rst_n(rst_n), .state(st_sat),
    .pip1_X(s_p1x), .pip1_Y(s_p1y), .pip2_X(s_p2x), .pip2_Y(s_p2y),
    .score(s_score), .pass_pulse(s_pass)
  );

  // clock / reset
  always #5 clk_ms = ~clk_ms;

  // reference LFSR; m_prev is the value the DUT saw on the latest edge
  always @(posedge clk_ms or negedge rst_n) begin
    if (!rst_n) begin
      m_lfsr <= 16'hACE1;
      m_prev <= 16'hACE1;
    end else begin
      m_prev <= m_lfsr;
      m_lfsr <= {m_lfsr[0] ^ m_lfsr[2] ^ m_lfsr[3] ^ m_lfsr[5], m_lfsr[15:1]};
    end
  end

  task automatic step(input int n);
    repeat (n) @(posedge clk_ms);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  initial begin
    // asynchronous reset before any clock edge
    #1 rst_n = 1'b0;
    #2;
    check("rst_p1x", 32'(m_p1x), 640);
    check("rst_p2x", 32'(m_p2x), 960);
    check("rst_p1y", 32'(m_p1y), 348);
    check("rst_p2y", 32'(m_p2y), 348);
    check("rst_score", 32'(m_score), 0);
    check("rst_pass", 32'(m_pass), 0);
    #9 rst_n = 1'b1;

    // idle: gap heights follow the LFSR every cycle
    step(3);
    exp_ya = 32'(220 + m_prev[7:0]);
    exp_yb = 32'(220 + m_prev[15:8]);
    check("idle_p1x", 32'(m_p1x), 640);
    check("idle_p2x", 32'(m_p2x), 960);
    check("idle_p1y", 32'(m_p1y), exp_ya);
    check("idle_p2y", 32'(m_p2y), exp_yb);

    // scroll timing
    st_main = 2'd1;
    step(1);  check("c1_p1x", 32'(m_p1x), 640);
    step(6);  check("c7_p1x", 32'(m_p1x), 640);
    step(1);  check("c8_p1x", 32'(m_p1x), 639);
    check("c8_p2x", 32'(m_p2x), 959);
    step(56); check("c64_p1x", 32'(m_p1x), 632);
    check("c64_pass", 32'(m_pass), 0);

    // first pass at cycle 2568
    step(2503);
    check("c2567_pass", 32'(m_pass), 0);
    check("c2567_score", 32'(m_score), 0);
    check("c2567_p1x", 32'(m_p1x), 320);
    step(1);
    check("c2568_pass", 32'(m_pass), 1);
    check("c2568_score", 32'(m_score), 1);
    check("c2568_p1x", 32'(m_p1x), 639);
    check("c2568_p2x", 32'(m_p2x), 319);
    check("c2568_p1y", 32'(m_p1y), exp_yb);
    check("c2568_p2y", 32'(m_p2y), exp_ya);
    step(1);
    check("c2569_pass", 32'(m_pass), 0);
    check("c2569_score", 32'(m_score), 1);

    // pipe A respawns on tick 641 while pipe B passes the bird
    step(2558);
    check("c5127_pass", 32'(m_pass), 0);
    check("c5127_p1x", 32'(m_p1x), 320);
    check("c5127_p2x", 32'(m_p2x), 0);
    step(1);
    y_new = 32'(220 + m_prev[7:0]);
    check("c5128_p1x", 32'(m_p1x), 639);
    check("c5128_p2x", 32'(m_p2x), 319);
    check("c5128_p1y", 32'(m_p1y), y_new);
    check("c5128_p2y", 32'(m_p2y), exp_yb);
    check("c5128_yrange", 32'(m_p1y >= 9'd220 && m_p1y <= 9'd475), 1);
    check("c5128_score", 32'(m_score), 2);
    check("c5128_pass", 32'(m_pass), 1);

    // freeze mid-scroll (div = 3)
    step(3);
    check("c5131_p1x", 32'(m_p1x), 639);
    st_main = 2'd2;
    for (int i = 0; i < 100; i++) begin
      step(1);
      check("frz_p1x", 32'(m_p1x), 639);
      check("frz_p2x", 32'(m_p2x), 319);
      check("frz_p1y", 32'(m_p1y), y_new);
      check("frz_score", 32'(m_score), 2);
      check("frz_pass", 32'(m_pass), 0);
    end

    // resume: divider was held, so the next tick is 5 edges away
    st_main = 2'd1;
    step(4); check("res4_p1x", 32'(m_p1x), 639);
    step(1); check("res5_p1x", 32'(m_p1x), 638);
    check("res5_p2x", 32'(m_p2x), 318);
    step(7); check("res12_p1x", 32'(m_p1x), 638);

    // idle overrides the tick that was due on this edge
    st_main = 2'd0;
    step(1);
    check("idle2_p1x", 32'(m_p1x), 640);
    check("idle2_p2x", 32'(m_p2x), 960);
    check("idle2_score", 32'(m_score), 0);
    check("idle2_pass", 32'(m_pass), 0);
    check("idle2_p1y", 32'(m_p1y), 32'(220 + m_prev[7:0]));

    // saturation on the SCORE_MAX=3 instance
    st_sat = 2'd1;
    step(7687);
    check("sat7687_score", 32'(s_score), 2);
    step(1);
    check("sat7688_score", 32'(s_score), 3);
    check("sat7688_pass", 32'(s_pass), 1);
    check("sat7688_p1x", 32'(s_p1x), 639);
    check("sat7688_p2x", 32'(s_p2x), 319);
    step(2559);
    check("sat10247_pass", 32'(s_pass), 0);
    check("sat10247_p1x", 32'(s_p1x), 320);
    step(1);
    check("sat10248_score", 32'(s_score), 3);
    check("sat10248_pass", 32'(s_pass), 1);
    check("sat10248_p1x", 32'(s_p1x), 639);
    check("sat10248_p2x", 32'(s_p2x), 319);
    step(1);
    check("sat10249_pass", 32'(s_pass), 0);
    check("sat10249_score", 32'(s_score), 3);

    // asynchronous reset mid-play, between clock edges
    #2 rst_n = 1'b0;
    #1;
    check("mrst_p1x", 32'(s_p1x), 640);
    check("mrst_p2x", 32'(s_p2x), 960);
    check("mrst_p1y", 32'(s_p1y), 348);
    check("mrst_score", 32'(s_score), 0);
    check("mrst_pass", 32'(s_pass), 0);
    check("mrst_main_p1y", 32'(m_p1y), 348);
    check("mrst_main_p2y", 32'(m_p2y), 348);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
